// File: rtl/bram_write_arbiter_pkg.sv
// Shared types and constants for the BRAM write arbiter: FSM encoding,
// grant index width and the fixed BRAM address map.
package bram_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   // grant_id is always 3 bits wide, enough for up to 8 requesters
   localparam int GRANT_W = 3;

   localparam logic [3:0] ADDR_MCC           = 4'd4;
   localparam logic [3:0] ADDR_RADAR         = 4'd5;
   localparam logic [3:0] ADDR_MCR           = 4'd6;
   localparam logic [3:0] ADDR_PROGRAM       = 4'd7;
   localparam logic [3:0] ADDR_POSITION_BASE = 4'd8;
   localparam logic [3:0] ADDR_POSITION_LAST = 4'd15;

endpackage

// File: rtl/bram_write_arbiter_rr_pick.sv
// Round-robin picker: first valid index searching upward from last_grant+1,
// wrapping modulo NUM_REQ, so last_grant itself has the lowest priority.
module bram_write_arbiter_rr_pick
   import bram_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [GRANT_W-1:0] last_grant_i,
   output logic [GRANT_W-1:0] idx_o,
   output logic               found_o
);

   // Walk distances from farthest to nearest so the nearest valid one wins
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == ((int'(last_grant_i) + k) % NUM_REQ)) && valid_i[i]) begin
               idx_o   = GRANT_W'(i);
               found_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ write requesters into a single
// BRAM writer port, with a per-write timeout on the writer's idle handshake.
module bram_write_arbiter
   import bram_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                      system_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        req_error,
   output logic                      bram_write_run,
   output logic [ADDR_W-1:0]         bram_addr,
   output logic [DATA_W-1:0]         bram_data,
   output logic                      bram_mode,
   input  logic                      bram_write_idle,
   output logic [2:0]                grant_id
);

   // One spare bit so the counter can never wrap while waiting
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [GRANT_W-1:0]  grant_id_q, grant_id_d;
   logic [GRANT_W-1:0]  last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GRANT_W-1:0]  pick_idx;
   logic                pick_found;

   bram_write_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .valid_i      (req_valid),
      .last_grant_i (last_grant_q),
      .idx_o        (pick_idx),
      .found_o      (pick_found)
   );

   always_comb begin
      state_d        = state_q;
      grant_id_d     = grant_id_q;
      last_grant_d   = last_grant_q;
      addr_d         = addr_q;
      data_d         = data_q;
      cnt_d          = cnt_q;
      req_ready      = '0;
      req_error      = '0;
      bram_write_run = 1'b0;
      bram_mode      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (GRANT_W'(i) == pick_idx) begin
                     req_ready[i] = 1'b1;
                     addr_d       = req_addr[i*ADDR_W +: ADDR_W];
                     data_d       = req_data[i*DATA_W +: DATA_W];
                  end
               end
               grant_id_d = pick_idx;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bram_write_run = 1'b1;
            bram_mode      = 1'b1;
            cnt_d          = '0;
            state_d        = ST_WAIT;
         end
         ST_WAIT: begin
            bram_mode = 1'b1;
            // idle is stale on the first WAIT cycle (writer just started)
            if ((cnt_q != '0) && bram_write_idle) begin
               state_d = ST_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (GRANT_W'(i) == grant_id_q) req_error[i] = 1'b1;
               end
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge system_clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GRANT_W'(NUM_REQ - 1);
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bram_addr = addr_q;
   assign bram_data = data_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_bram_write_arbiter;
   localparam int NR = 4;
   localparam int AW = 10;
   localparam int DW = 32;

   logic              system_clk = 1'b0;
   logic              reset = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready, req_error;
   logic              bram_write_run, bram_mode;
   logic              bram_write_idle = 1'b0;
   logic [AW-1:0]     bram_addr;
   logic [DW-1:0]     bram_data;
   logic [2:0]        grant_id;

   int checks = 0;
   int errors = 0;

   bram_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
      .system_clk      (system_clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .req_error       (req_error),
      .bram_write_run  (bram_write_run),
      .bram_addr       (bram_addr),
      .bram_data       (bram_data),
      .bram_mode       (bram_mode),
      .bram_write_idle (bram_write_idle),
      .grant_id        (grant_id)
   );

   always #5 system_clk = ~system_clk;

   task automatic tick();
      @(negedge system_clk);
   endtask

   task automatic test_reset();
      #12;
      checks++; if ({req_ready, req_error} !== 8'h00) begin errors++; $display("FAIL reset_pulses got %h want 00", {req_ready, req_error}); end
      checks++; if ({bram_write_run, bram_mode} !== 2'b00) begin errors++; $display("FAIL reset_run_mode got %b want 00", {bram_write_run, bram_mode}); end
      checks++; if ({bram_addr, bram_data, grant_id} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%0d want 0", bram_addr, bram_data, grant_id); end
      tick(); reset = 1'b1;
   endtask

   task automatic test_single();
      tick();
      req_valid = 4'b0100; req_addr[2*AW +: AW] = 10'd5; req_data[2*DW +: DW] = 32'hDEADBEEF;
      bram_write_idle = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
      checks++; if (bram_write_run !== 1'b0) begin errors++; $display("FAIL single_run_early got %b want 0", bram_write_run); end
      tick(); req_valid = '0; #1;
      checks++; if ({bram_write_run, bram_mode} !== 2'b11) begin errors++; $display("FAIL single_issue got %b want 11", {bram_write_run, bram_mode}); end
      checks++; if (bram_addr !== 10'd5 || bram_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_latch got %h/%h want 005/deadbeef", bram_addr, bram_data); end
      checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
      tick(); bram_write_idle = 1'b1; #1;
      checks++; if ({bram_write_run, bram_mode} !== 2'b01) begin errors++; $display("FAIL single_wait0 got %b want 01", {bram_write_run, bram_mode}); end
      tick(); #1;
      checks++; if (bram_mode !== 1'b1) begin errors++; $display("FAIL single_wait1 got %b want 1", bram_mode); end
      tick(); #1;
      checks++; if (bram_mode !== 1'b0) begin errors++; $display("FAIL single_release got %b want 0", bram_mode); end
      checks++; if (bram_addr !== 10'd5) begin errors++; $display("FAIL single_hold got %h want 005", bram_addr); end
      tick(); bram_write_idle = 1'b0;
   endtask

   task automatic test_round_robin();
      int seq[5];
      int n = 0;
      reset = 1'b0; #2; reset = 1'b1;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(16 + i);
      tick(); req_valid = 4'hF; bram_write_idle = 1'b1;
      for (int c = 0; c < 40 && n < 5; c++) begin
         if (c != 0) tick();
         #1;
         if (req_ready != '0) begin
            for (int i = 0; i < NR; i++) if (req_ready[i]) seq[n] = i;
            n++;
         end
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL rr_count got %0d want 5", n); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (seq[k] !== k % 4) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, seq[k], k % 4); end
      end
      tick(); req_valid = '0; #1;
      checks++; if (bram_addr !== 10'd16) begin errors++; $display("FAIL rr_addr got %h want 010", bram_addr); end
      repeat (4) tick();
      bram_write_idle = 1'b0;
   endtask

   task automatic test_timeout();
      logic early = 1'b0;
      tick(); req_valid = 4'b0010; #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_ready got %b want 0010", req_ready); end
      tick(); req_valid = '0;
      for (int w = 0; w < 8; w++) begin
         tick(); #1;
         if (w < 7 && req_error != '0) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", early); end
      checks++; if (req_error !== 4'b0010) begin errors++; $display("FAIL to_error got %b want 0010", req_error); end
      tick(); #1;
      checks++; if ({bram_mode, req_error} !== 5'b0) begin errors++; $display("FAIL to_release got %b want 00000", {bram_mode, req_error}); end
      tick(); req_valid = 4'b1000; #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_back_idle got %b want 1000", req_ready); end
      tick(); req_valid = '0; bram_write_idle = 1'b1;
      repeat (4) tick();
      bram_write_idle = 1'b0;
   endtask

   task automatic test_idle_at_timeout();
      tick(); req_valid = 4'b0001; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL tie_ready got %b want 0001", req_ready); end
      tick(); req_valid = '0;
      repeat (7) tick();
      tick(); bram_write_idle = 1'b1; #1;
      checks++; if (req_error !== 4'b0000 || bram_mode !== 1'b1) begin errors++; $display("FAIL tie_no_error got %b/%b want 0000/1", req_error, bram_mode); end
      tick(); #1;
      checks++; if ({bram_mode, req_error} !== 5'b0) begin errors++; $display("FAIL tie_release got %b want 00000", {bram_mode, req_error}); end
      tick(); bram_write_idle = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      tick(); req_valid = 4'b0100;
      tick(); req_valid = '0;
      tick(); tick(); #1;
      checks++; if (bram_mode !== 1'b1) begin errors++; $display("FAIL rst_pre_mode got %b want 1", bram_mode); end
      #1 reset = 1'b0; #1;
      checks++; if ({bram_write_run, bram_mode, req_ready, req_error} !== 10'b0) begin errors++; $display("FAIL rst_async_ctl got %b want 0", {bram_write_run, bram_mode, req_ready, req_error}); end
      checks++; if ({bram_addr, bram_data, grant_id} !== '0) begin errors++; $display("FAIL rst_async_regs got %h/%h/%0d want 0", bram_addr, bram_data, grant_id); end
      tick(); reset = 1'b1; req_valid = 4'b1011; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_prio got %b want 0001", req_ready); end
      tick(); req_valid = '0; #1;
      checks++; if (grant_id !== 3'd0 || bram_write_run !== 1'b1) begin errors++; $display("FAIL rst_grant got %0d/%b want 0/1", grant_id, bram_write_run); end
      bram_write_idle = 1'b1;
      repeat (4) tick();
      bram_write_idle = 1'b0;
   endtask

   task automatic test_valid_during_wait();
      logic seen = 1'b0;
      tick(); req_valid = 4'b1000; #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL vdw_ready got %b want 1000", req_ready); end
      tick(); req_valid = '0;
      tick(); req_valid = 4'b0010; #1; seen |= |req_ready;
      tick(); req_valid = 4'b0010; #1; seen |= |req_ready;
      tick(); req_valid = '0; #1; seen |= |req_ready;
      tick(); bram_write_idle = 1'b1; #1; seen |= |req_ready;
      tick(); bram_write_idle = 1'b0; #1; seen |= |req_ready;
      repeat (3) begin tick(); #1; seen |= |req_ready; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL vdw_no_accept got %b want 0", seen); end
      checks++; if (grant_id !== 3'd3 || bram_mode !== 1'b0) begin errors++; $display("FAIL vdw_state got %0d/%b want 3/0", grant_id, bram_mode); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_idle_at_timeout();
      test_reset_mid_wait();
      test_valid_during_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_write_arbiter.md
BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 10: BRAM word address width.
REQ-003 Parameter DATA_W, default 32: BRAM word width.
REQ-004 Parameter TIMEOUT_CYCLES, default 8: maximum WAIT cycles before abandoning a write.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 system_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester write request; held high until accepted.
REQ-009 req_addr  in  NUM_REQ*ADDR_W  per-requester address, slice i = bits [i*ADDR_W +: ADDR_W].
REQ-010 req_data  in  NUM_REQ*DATA_W  per-requester data, sliced the same way.
REQ-011 req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot or zero.
REQ-012 req_error  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-013 bram_write_run  out  1  one-cycle start pulse to the downstream BRAM writer.
REQ-014 bram_addr  out  ADDR_W  latched address of the granted write.
REQ-015 bram_data  out  DATA_W  latched data of the granted write.
REQ-016 bram_mode  out  1  high while the arbiter owns the BRAM port.
REQ-017 bram_write_idle  in  1  downstream writer idle/done indication.
REQ-018 grant_id  out  3  index of the current or last granted requester.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RELEASE; the state register resets to IDLE.
REQ-020 IDLE: if any req_valid is high, the arbiter SHALL choose the first valid index searching round-robin from last_grant+1 (mod NUM_REQ), latch its addr/data into bram_addr/bram_data, pulse req_ready[i] in that same cycle, set grant_id, and go to ISSUE.
REQ-021 IDLE with no valid request: stay in IDLE, all pulses low.
REQ-022 ISSUE: bram_write_run=1 for exactly one cycle, bram_mode=1, timeout counter cleared, go to WAIT.
REQ-023 WAIT: bram_write_run=0 and bram_mode=1; bram_write_idle SHALL be ignored on the first WAIT cycle.
REQ-024 WAIT, after the first cycle: bram_write_idle=1 -> RELEASE.
REQ-025 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without idle, pulse req_error[grant_id] for one cycle and go to RELEASE.
REQ-026 RELEASE: bram_mode=0; last_grant <= grant_id; go to IDLE.
REQ-027 Latency: req_valid high in IDLE -> req_ready that cycle -> bram_write_run next cycle.
REQ-028 Minimum transaction is 4 cycles; back-to-back grants are separated by at least one IDLE cycle.
REQ-029 Requests are not sampled outside IDLE; a requester dropping valid before it sees ready is not granted.
REQ-030 bram_addr/bram_data SHALL hold their latched values until the next grant.
REQ-031 If idle and timeout occur in the same cycle, idle wins and no error is pulsed.
REQ-032 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL not wrap within WAIT.

Reset
REQ-033 Reset assertion in any state, including mid-WAIT, SHALL immediately set state=IDLE, req_ready=0, req_error=0, bram_write_run=0, bram_mode=0, bram_addr=0, bram_data=0, grant_id=0, counter=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-034 A write abandoned by reset SHALL NOT be retried.

Structure
REQ-035 FSM state encodings and the BRAM address map constants (MCC/RADAR/MCR/PROGRAM/POSITION, 4..15) SHALL live in the shared package.
REQ-036 A round-robin priority picker (rr_pick: inputs valid vector and last_grant, output index and found flag) is the one natural sub-module.

Verification
REQ-037 Single request: req_valid[2]=1, addr=5, data=32'hDEADBEEF -> req_ready[2] pulse, then bram_write_run pulse next cycle with bram_addr=5 and bram_data=DEADBEEF; idle after 2 cycles -> bram_mode low in RELEASE.
REQ-038 All four requesting continuously -> grant order 0,1,2,3,0 and each requester accepted once per 4 transactions.
REQ-039 bram_write_idle held 0 -> req_error pulse to the granted index after 8 WAIT cycles, then return to IDLE.
REQ-040 Idle rises in the same cycle the counter hits 7 -> no req_error.
REQ-041 Reset asserted during WAIT -> all outputs 0 asynchronously; after release, requester 0 wins over 1 and 3.
REQ-042 req_valid[1] pulsed only during WAIT of another grant -> never accepted.
